imem_loader: RTL and testbench

Program loader that fills the byte-addressed instruction memory before the core runs. It accepts a framed byte stream over a valid/ready handshake, packs little-endian bytes into 32-bit words and drives the instruction memory's synchronous write port. It also checks an XOR checksum and holds the core in reset until the image is loaded. It sits between the external byte source (UART/testbench) and the instruction memory write port.

---
 rtl/imem_load_pkg.sv | 21 ++
 rtl/imem_loader_word_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 136 +++++++++++++
 tb/tb_imem_loader.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_load_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_load_pkg;

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        CHK,
        DONE,
        ERR
    } load_state_e;

    localparam int LEN_W  = 16;
    localparam int WORD_W = 32;
    localparam int BYTE_W = 8;

    function automatic int max_words(input int mem_bytes);
        return mem_bytes / 4;
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words; word_valid pulses
// combinationally with the byte that completes a word.
module word_assembler
    import imem_load_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]        idx_q, idx_d;
    logic [WORD_W-1:0] word_q, word_d;

    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        if (byte_valid) begin
            word_d[idx_q*BYTE_W +: BYTE_W] = byte_in;
            idx_d = idx_q + 2'd1;
        end
    end

    // The completing byte is merged into the outgoing word in the same cycle.
    assign word_valid = byte_valid && (idx_q == 2'd3);
    assign word       = word_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q  <= '0;
            word_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader: fills instruction memory, checks an XOR checksum
// and holds the core in reset until a good image has been loaded.
module imem_loader
    import imem_load_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int ADR_W     = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADR_W-1:0]  mem_adr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [LEN_W-1:0]  words_loaded
);

    localparam logic [LEN_W-1:0] MAX_WORDS = LEN_W'(max_words(MEM_BYTES));

    load_state_e       state_q, state_d;
    logic [BYTE_W-1:0] len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [BYTE_W-1:0] chk_q, chk_d;
    logic [LEN_W-1:0]  word_idx_q, word_idx_d;
    logic              mem_we_q, mem_we_d;
    logic [ADR_W-1:0]  mem_adr_q, mem_adr_d;
    logic [WORD_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              xfer;
    logic              asm_valid;
    logic              word_valid;
    logic [WORD_W-1:0] word;

    assign in_ready  = rst && (state_q inside {HDR_LO, HDR_HI, DATA, CHK});
    assign xfer      = in_valid && in_ready;
    assign asm_valid = xfer && (state_q == DATA);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .byte_valid (asm_valid),
        .byte_in    (in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    always_comb begin
        state_d     = state_q;
        len_lo_d    = len_lo_q;
        len_d       = len_q;
        chk_d       = chk_q;
        word_idx_d  = word_idx_q;
        mem_we_d    = 1'b0;
        mem_adr_d   = mem_adr_q;
        mem_wdata_d = mem_wdata_q;

        if (xfer && state_q != CHK) begin
            chk_d = chk_q ^ in_data;
        end

        unique case (state_q)
            HDR_LO: begin
                if (xfer) begin
                    len_lo_d = in_data;
                    state_d  = HDR_HI;
                end
            end
            HDR_HI: begin
                if (xfer) begin
                    len_d = {in_data, len_lo_q};
                    if (len_d > MAX_WORDS) begin
                        state_d = ERR;
                    end else if (len_d == '0) begin
                        state_d = CHK;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (word_valid) begin
                    mem_we_d    = 1'b1;
                    mem_adr_d   = ADR_W'({word_idx_q, 2'b00});
                    mem_wdata_d = word;
                    word_idx_d  = word_idx_q + 1'b1;
                    if (word_idx_d == len_q) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (xfer) begin
                    state_d = (in_data == chk_q) ? DONE : ERR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= HDR_LO;
            len_lo_q    <= '0;
            len_q       <= '0;
            chk_q       <= '0;
            word_idx_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_adr_q   <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            len_lo_q    <= len_lo_d;
            len_q       <= len_d;
            chk_q       <= chk_d;
            word_idx_q  <= word_idx_d;
            mem_we_q    <= mem_we_d;
            mem_adr_q   <= mem_adr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // The word counter advances on the same edge that raises mem_we.
    assign words_loaded = word_idx_q;
    assign mem_we       = mem_we_q;
    assign mem_adr      = mem_adr_q;
    assign mem_wdata    = mem_wdata_q;
    assign done         = (state_q == DONE);
    assign err          = (state_q == ERR);
    assign cpu_hold     = (state_q != DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames compared
// against a frame-level reference model.
module tb_imem_loader;

   localparam int MEM_BYTES = 64;
   localparam int ADR_W     = 64;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              inValid = 1'b0;
   logic [7:0]        inData = 8'h00;
   logic              inReady;
   logic              memWe;
   logic [ADR_W-1:0]  memAdr;
   logic [31:0]       memWdata;
   logic              cpuHold;
   logic              done;
   logic              err;
   logic [15:0]       wordsLoaded;

   imem_loader #(.MEM_BYTES(MEM_BYTES), .ADR_W(ADR_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (inValid),
      .in_data      (inData),
      .in_ready     (inReady),
      .mem_we       (memWe),
      .mem_adr      (memAdr),
      .mem_wdata    (memWdata),
      .cpu_hold     (cpuHold),
      .done         (done),
      .err          (err),
      .words_loaded (wordsLoaded)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] adr;
      logic [31:0] data;
      int          wl;
      int          cyc;
   } wr_t;

   int         testsRun = 0;
   int         failCount = 0;
   int         cycle = 0;
   wr_t        gotQ[$];
   wr_t        expQ[$];
   logic [7:0] frameQ[$];
   logic [7:0] dataQ[$];
   bit         expDone;
   bit         expErr;
   int         consumed;

   always @(posedge clk) cycle++;

   always @(negedge clk) begin
      if (rst && memWe)
         gotQ.push_back('{adr: memAdr, data: memWdata, wl: int'(wordsLoaded), cyc: cycle});
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b, input int gapPct);
      while (int'($urandom_range(0, 99)) < gapPct) begin
         inValid = 1'b0;
         inData  = 8'($urandom);
         @(posedge clk); #1;
      end
      inValid = 1'b1;
      inData  = b;
      @(posedge clk); #1;
   endtask

   task automatic buildFrame(input logic [7:0] nLo, input logic [7:0] nHi, input bit corrupt);
      logic [7:0] x;
      frameQ = {};
      frameQ.push_back(nLo);
      frameQ.push_back(nHi);
      foreach (dataQ[i]) frameQ.push_back(dataQ[i]);
      x = 8'h00;
      foreach (frameQ[i]) x = x ^ frameQ[i];
      frameQ.push_back(corrupt ? (x ^ 8'h5A) : x);
   endtask

   task automatic modelFrame();
      int         n;
      logic [7:0] x;
      expQ    = {};
      expDone = 1'b0;
      expErr  = 1'b0;
      n = int'(frameQ[0]) + 256 * int'(frameQ[1]);
      if (n > MEM_BYTES / 4) begin
         expErr   = 1'b1;
         consumed = 2;
         return;
      end
      for (int w = 0; w < n; w++) begin
         int b = 2 + 4 * w;
         expQ.push_back('{adr: 64'(4 * w),
                          data: {frameQ[b+3], frameQ[b+2], frameQ[b+1], frameQ[b]},
                          wl: w + 1, cyc: 0});
      end
      consumed = 2 + 4 * n + 1;
      x = 8'h00;
      for (int i = 0; i < consumed - 1; i++) x = x ^ frameQ[i];
      expErr  = (frameQ[consumed-1] != x);
      expDone = !expErr;
   endtask

   task automatic runFrame(input string name, input int gapPct);
      int m;
      modelFrame();
      gotQ = {};
      for (int i = 0; i < consumed; i++) applyStimulus(frameQ[i], gapPct);
      inValid = 1'b0;
      @(negedge clk);
      checkOutput({name, " done"}, 64'(done), 64'(expDone));
      checkOutput({name, " err"}, 64'(err), 64'(expErr));
      checkOutput({name, " cpu_hold"}, 64'(cpuHold), 64'(!expDone));
      checkOutput({name, " in_ready"}, 64'(inReady), 64'(0));
      repeat (2) @(negedge clk);
      checkOutput({name, " write count"}, 64'(gotQ.size()), 64'(expQ.size()));
      checkOutput({name, " words_loaded"}, 64'(wordsLoaded), 64'(expQ.size()));
      m = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
      for (int i = 0; i < m; i++) begin
         checkOutput({name, " adr"}, gotQ[i].adr, expQ[i].adr);
         checkOutput({name, " wdata"}, 64'(gotQ[i].data), 64'(expQ[i].data));
         checkOutput({name, " wl at we"}, 64'(gotQ[i].wl), 64'(expQ[i].wl));
         if (gapPct == 0 && i > 0)
            checkOutput({name, " we spacing"}, 64'(gotQ[i].cyc - gotQ[i-1].cyc), 64'(4));
      end
   endtask

   task automatic doReset();
      inValid = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic checkResetValues(input string name);
      checkOutput({name, " in_ready"}, 64'(inReady), 64'(0));
      checkOutput({name, " mem_we"}, 64'(memWe), 64'(0));
      checkOutput({name, " mem_adr"}, memAdr, 64'(0));
      checkOutput({name, " mem_wdata"}, 64'(memWdata), 64'(0));
      checkOutput({name, " cpu_hold"}, 64'(cpuHold), 64'(1));
      checkOutput({name, " done"}, 64'(done), 64'(0));
      checkOutput({name, " err"}, 64'(err), 64'(0));
      checkOutput({name, " words_loaded"}, 64'(wordsLoaded), 64'(0));
   endtask

   initial begin
      int n;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkResetValues("reset");
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      checkOutput("ready after reset", 64'(inReady), 64'(1));

      dataQ = {8'h63, 8'h00, 8'h00, 8'h00};
      buildFrame(8'h01, 8'h00, 1'b0);
      checkOutput("single chk byte", 64'(frameQ[6]), 64'(8'h62));
      runFrame("single", 0);

      doReset();
      dataQ = {8'h33, 8'h04, 8'h04, 8'h00, 8'h33, 8'h74, 8'h80, 8'h00, 8'h33, 8'h68, 8'h88, 8'h00};
      buildFrame(8'h03, 8'h00, 1'b0);
      runFrame("three", 0);

      doReset();
      runFrame("three gaps", 40);

      doReset();
      dataQ = {8'h63, 8'h00, 8'h00, 8'h00};
      buildFrame(8'h01, 8'h00, 1'b1);
      runFrame("bad chk", 0);

      doReset();
      dataQ = {};
      buildFrame(8'h11, 8'h00, 1'b0);
      runFrame("oversize", 0);

      doReset();
      dataQ = {};
      buildFrame(8'h00, 8'h00, 1'b0);
      runFrame("zero len", 0);

      doReset();
      dataQ = {};
      for (int i = 0; i < 64; i++) dataQ.push_back(8'($urandom));
      buildFrame(8'h10, 8'h00, 1'b0);
      runFrame("full mem", 0);

      for (int k = 0; k < 6; k++) begin
         doReset();
         n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(17, 20)) : int'($urandom_range(0, 16));
         dataQ = {};
         for (int i = 0; i < 4 * n; i++) dataQ.push_back(8'($urandom));
         buildFrame(8'(n), 8'h00, $urandom_range(0, 3) == 0);
         runFrame("random", (k % 2 == 0) ? 0 : 30);
      end

      doReset();
      dataQ = {8'h13, 8'h05, 8'h50, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
      buildFrame(8'h02, 8'h00, 1'b0);
      gotQ = {};
      for (int i = 0; i < 8; i++) applyStimulus(frameQ[i], 0);
      inValid = 1'b0;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkResetValues("mid reset");
      checkOutput("mid reset writes", 64'(gotQ.size()), 64'(1));
      if (gotQ.size() > 0)
         checkOutput("mid reset word", 64'(gotQ[0].data), 64'({dataQ[3], dataQ[2], dataQ[1], dataQ[0]}));
      @(posedge clk); #1 rst = 1'b1;
      dataQ = {8'h6F, 8'h00, 8'h00, 8'h00};
      buildFrame(8'h01, 8'h00, 1'b0);
      runFrame("after mid reset", 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
